// File: rtl/mmio_uart_tx_pkg.sv
// Purpose : shared definitions for the memory-mapped UART transmitter:
//           default register addresses, status-word bit positions, frame FSM
//           state encoding and a helper that packs the status word.
// Ports   : none (package).
package mmio_uart_tx_pkg;

   localparam logic [31:0] DATA_ADDR_DEF = 32'hFFFF_FC80;
   localparam logic [31:0] STAT_ADDR_DEF = 32'hFFFF_FC84;

   localparam int STAT_IDLE_BIT = 0;
   localparam int STAT_FULL_BIT = 1;
   localparam int STAT_OVF_BIT  = 2;
   localparam int STAT_CNT_LSB  = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_e;

   function automatic logic [15:0] build_status(input logic       idle,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic [3:0] count);
      logic [15:0] s;
      s = '0;
      s[STAT_IDLE_BIT]                 = idle;
      s[STAT_FULL_BIT]                 = full;
      s[STAT_OVF_BIT]                  = ovf;
      s[STAT_CNT_LSB+3:STAT_CNT_LSB]   = count;
      return s;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Purpose : small byte FIFO with registered pointers and occupancy count.
//           Pushes while full and pops while empty are ignored; both flags
//           come from the registered count.
// Ports   : clk, rst (sync, active-high), push/din[7:0] write side,
//           pop/dout[7:0] read side (dout shows the head entry),
//           count[$clog2(DEPTH):0], full, empty.
module byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [7:0]             din,
   input  logic                   pop,
   output logic [7:0]             dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap at DEPTH by plain overflow.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; entries are only observable after
   // being written, and leaving it out lets it map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Purpose : memory-mapped 8N1 UART transmitter on the CPU IO bus. Stores to
//           DATA_ADDR queue a byte; loads from STAT_ADDR return idle/full/
//           overflow/count. Queued bytes go out back-to-back on tx.
// Ports   : clk, rst (sync, active-high), address[31:0], writeData[31:0]
//           (bits [7:0] used), ioWrite, ioRead strobes, rdata[15:0]
//           (combinational load data), tx (registered serial line, idle high).
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter int          CLK_HZ     = 23_000_000,
   parameter int          BAUD       = 9600,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] DATA_ADDR  = DATA_ADDR_DEF,
   parameter logic [31:0] STAT_ADDR  = STAT_ADDR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   input  logic        ioWrite,
   input  logic        ioRead,
   output logic [15:0] rdata,
   output logic        tx
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int BCW          = $clog2(CLKS_PER_BIT);
   localparam int CW           = $clog2(FIFO_DEPTH) + 1;

   logic          push;
   logic          pop;
   logic          stat_sel;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          tick;
   logic          unused_bits;

   uart_state_e   state_q, state_d;
   logic [BCW-1:0] baud_q, baud_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_d;

   assign push        = ioWrite && (address == DATA_ADDR);
   assign stat_sel    = ioRead && (address == STAT_ADDR);
   assign unused_bits = ^writeData[31:8];

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (writeData[7:0]),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   // The load sees the pre-clear overflow value; a drop in the same cycle
   // as a status read wins so no overflow event is lost.
   always_ff @(posedge clk) begin
      if (rst)                 overflow <= 1'b0;
      else if (push && full)   overflow <= 1'b1;
      else if (stat_sel)       overflow <= 1'b0;
   end

   assign rdata = stat_sel
                ? build_status(empty && (state_q == S_IDLE), full, overflow, 4'(fifo_count))
                : 16'h0000;

   assign tick = (baud_q == BCW'(CLKS_PER_BIT - 1));

   // NOTE: every output of this block is assigned a default first so no path
   // leaves a value unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      baud_d  = (state_q == S_IDLE || tick) ? '0 : baud_q + 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               idx_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 1'b1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            // Chain straight into the next start bit when more bytes wait.
            if (tick) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_dout;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // tx is registered from the next state, so each level lasts exactly
      // one full bit period and starts on the edge the state changes.
      unique case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx      <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx      <= tx_d;
      end
   end

endmodule
